// File: rtl/channel_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// channel_ctrl_pkg
// Shared types and constants for the LArPix per-channel sequencer.
//   state_t      : sequencer states
//   MISSED_MAX   : saturation value of the missed-hit counter
//   rearm_last() : last count index of the CSA reset window (0 is treated as 1)
// -----------------------------------------------------------------------------
package channel_ctrl_pkg;

    typedef enum logic [2:0] {
        RESET,
        ARMED,
        HOLD,
        SAMPLE,
        CONVERT,
        STORE
    } state_t;

    localparam logic [7:0] MISSED_MAX = 8'hFF;

    // The reset window lasts max(reset_cycles, 1) cycles; the counter starts
    // at 0 on entry, so the window ends when it reaches this value.
    function automatic logic [7:0] rearm_last(input logic [7:0] reset_cycles);
        return (reset_cycles == 8'd0) ? 8'd0 : reset_cycles - 8'd1;
    endfunction

endpackage

// File: rtl/sync_edge.sv
// -----------------------------------------------------------------------------
// sync_edge
// Two-flop synchroniser for an asynchronous level, plus a one-cycle pulse on
// its synchronised rising edge.
//   clk       in  system clock
//   reset_n   in  synchronous active-low reset
//   async_in  in  asynchronous input level
//   level     out synchronised level (2 cycles after async_in)
//   rise      out one-cycle pulse on the rising edge of level
// -----------------------------------------------------------------------------
module sync_edge (
    input  logic clk,
    input  logic reset_n,
    input  logic async_in,
    output logic level,
    output logic rise
);

    // sr[0], sr[1]: synchroniser stages; sr[2]: previous value of sr[1].
    logic [2:0] sr;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sr <= '0;
        end else begin
            sr <= {sr[1:0], async_in};
        end
    end

    assign level = sr[1];
    assign rise  = sr[1] & ~sr[2];

endmodule

// File: rtl/channel_ctrl.sv
// -----------------------------------------------------------------------------
// channel_ctrl
// Per-channel sequencer for the LArPix analog channel (CSA, discriminator,
// SAR ADC): arms the CSA, waits for a hit, holds, pulses the ADC sample,
// waits for conversion done and hands code + timestamp to the event builder
// through a one-deep valid/ready buffer, then re-arms the CSA.
//
// Optional feature: define CHANNEL_CTRL_TIMEOUT_EN to bound the wait for
// done to TIMEOUT_CYCLES; on expiry timeout_err is set (sticky) and an
// all-ones code is emitted. Without it timeout_err is tied to 0.
//
// Ports
//   clk, reset_n          clock, synchronous active-low reset
//   hit, done             asynchronous discriminator / ADC-done inputs
//   dout                  ADC code, stable while done is high
//   enable                channel enable
//   hold_delay            cycles from hit detect to sample (0 = next cycle)
//   reset_cycles          csa_reset width per re-arm (0 treated as 1)
//   csa_reset, sample     strobes to the analog channel
//   data_valid/ready      output handshake
//   data_word, data_ts    captured ADC code and hit-detect timestamp
//   missed_hits           saturating count of hits seen outside ARMED
//   timeout_err           sticky conversion timeout flag
// -----------------------------------------------------------------------------
module channel_ctrl
    import channel_ctrl_pkg::*;
#(
    parameter int ADCBITS        = 10,
    parameter int TS_BITS        = 24,
    parameter int SAMPLE_CYCLES  = 2,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               hit,
    input  logic               done,
    input  logic [ADCBITS-1:0] dout,
    input  logic               enable,
    input  logic [7:0]         hold_delay,
    input  logic [7:0]         reset_cycles,
    output logic               csa_reset,
    output logic               sample,
    output logic               data_valid,
    input  logic               data_ready,
    output logic [ADCBITS-1:0] data_word,
    output logic [TS_BITS-1:0] data_ts,
    output logic [7:0]         missed_hits,
    output logic               timeout_err
);

    state_t               state, state_n;
    logic [7:0]           cnt, cnt_n;
    logic [TS_BITS-1:0]   ts;
    logic [TS_BITS-1:0]   ts_latch;
    logic [ADCBITS-1:0]   cap_word;
    logic                 hit_s, hit_rise, done_s, done_rise;
    logic                 latch_ts, cap_load, store_load, missed_inc;

    sync_edge u_hit_sync (
        .clk      (clk),
        .reset_n  (reset_n),
        .async_in (hit),
        .level    (hit_s),
        .rise     (hit_rise)
    );

    sync_edge u_done_sync (
        .clk      (clk),
        .reset_n  (reset_n),
        .async_in (done),
        .level    (done_s),
        .rise     (done_rise)
    );

    // Only the hit edge and the done level are used.
    logic unused_sync_bits;
    assign unused_sync_bits = hit_s ^ done_rise;

`ifdef CHANNEL_CTRL_TIMEOUT_EN
    localparam int               TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    logic [TMO_W-1:0] tmo_cnt;
    logic             tmo_fire;
    logic             timeout_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            tmo_cnt   <= '0;
            timeout_q <= 1'b0;
        end else begin
            // Counter is held at zero outside CONVERT so each wait starts fresh.
            tmo_cnt <= (state == CONVERT) ? tmo_cnt + TMO_W'(1) : '0;
            if (tmo_fire) begin
                timeout_q <= 1'b1;
            end
        end
    end

    assign timeout_err = timeout_q;
`else
    // Keeps the parameter list identical in both builds.
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
    assign timeout_err = 1'b0;
`endif

    assign missed_inc = hit_rise && (state != ARMED);
    assign csa_reset  = (state == RESET);
    assign sample     = (state == SAMPLE);

    always_comb begin
        // NOTE: every combinational output is given a default before the case
        // so no path leaves it unassigned and no latch is inferred.
        state_n    = state;
        cnt_n      = cnt;
        latch_ts   = 1'b0;
        cap_load   = 1'b0;
        store_load = 1'b0;
`ifdef CHANNEL_CTRL_TIMEOUT_EN
        tmo_fire   = 1'b0;
`endif
        case (state)
            RESET: begin
                if (cnt >= rearm_last(reset_cycles)) begin
                    if (enable) begin
                        state_n = ARMED;
                    end
                end else begin
                    cnt_n = cnt + 8'd1;
                end
            end
            ARMED: begin
                // Enable dropping takes priority: a coincident hit is ignored.
                if (!enable) begin
                    state_n = RESET;
                    cnt_n   = '0;
                end else if (hit_rise) begin
                    state_n  = HOLD;
                    cnt_n    = hold_delay;
                    latch_ts = 1'b1;
                end
            end
            HOLD: begin
                if (cnt == 8'd0) begin
                    state_n = SAMPLE;
                    cnt_n   = 8'(SAMPLE_CYCLES - 1);
                end else begin
                    cnt_n = cnt - 8'd1;
                end
            end
            SAMPLE: begin
                if (cnt == 8'd0) begin
                    state_n = CONVERT;
                end else begin
                    cnt_n = cnt - 8'd1;
                end
            end
            CONVERT: begin
                if (done_s) begin
                    cap_load = 1'b1;
                    state_n  = STORE;
                end
`ifdef CHANNEL_CTRL_TIMEOUT_EN
                else if (tmo_cnt == TMO_LAST) begin
                    tmo_fire = 1'b1;
                    state_n  = STORE;
                end
`endif
            end
            STORE: begin
                // The buffer can take a new word when empty or when the
                // current word leaves this very cycle.
                if (!data_valid || data_ready) begin
                    store_load = 1'b1;
                    state_n    = RESET;
                    cnt_n      = '0;
                end
            end
            default: begin
                state_n = RESET;
                cnt_n   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= RESET;
            cnt         <= '0;
            ts          <= '0;
            ts_latch    <= '0;
            cap_word    <= '0;
            data_valid  <= 1'b0;
            data_word   <= '0;
            data_ts     <= '0;
            missed_hits <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            state <= state_n;
            cnt   <= cnt_n;
            ts    <= ts + TS_BITS'(1);

            if (latch_ts) begin
                ts_latch <= ts;
            end

            if (cap_load) begin
                cap_word <= dout;
            end
`ifdef CHANNEL_CTRL_TIMEOUT_EN
            else if (tmo_fire) begin
                cap_word <= '1;
            end
`endif

            if (store_load) begin
                data_word  <= cap_word;
                data_ts    <= ts_latch;
                data_valid <= 1'b1;
            end else if (data_valid && data_ready) begin
                data_valid <= 1'b0;
            end

            if (missed_inc && (missed_hits != MISSED_MAX)) begin
                missed_hits <= missed_hits + 8'd1;
            end
        end
    end

endmodule
